// File: rtl/iob_uart16550_init_arb.sv
// UART 16550 init sequencer and host arbiter.
// After reset (or a start_i request) it programs the divisor latch, line
// control, FIFO control and interrupt enable registers of the UART. It then
// hands the IOb bus to the host as a combinational passthrough.
module iob_uart16550_init_arb #(
  parameter int         ADDR_W  = 3,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] IER_VAL = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  start_i,
  input  logic [15:0]           div_i,
  output logic                  busy_o,
  output logic                  done_o,
  // host side (IOb slave)
  input  logic                  h_iob_avalid_i,
  input  logic [ADDR_W-1:0]     h_iob_addr_i,
  input  logic [DATA_W-1:0]     h_iob_wdata_i,
  input  logic [DATA_W/8-1:0]   h_iob_wstrb_i,
  output logic                  h_iob_rvalid_o,
  output logic [DATA_W-1:0]     h_iob_rdata_o,
  output logic                  h_iob_ready_o,
  // UART side (IOb master)
  output logic                  u_iob_avalid_o,
  output logic [ADDR_W-1:0]     u_iob_addr_o,
  output logic [DATA_W-1:0]     u_iob_wdata_o,
  output logic [DATA_W/8-1:0]   u_iob_wstrb_o,
  input  logic                  u_iob_rvalid_i,
  input  logic [DATA_W-1:0]     u_iob_rdata_i,
  input  logic                  u_iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] INIT_DLAB = 3'd0;
  localparam logic [2:0] INIT_DLL  = 3'd1;
  localparam logic [2:0] INIT_DLM  = 3'd2;
  localparam logic [2:0] INIT_LCR  = 3'd3;
  localparam logic [2:0] INIT_FCR  = 3'd4;
  localparam logic [2:0] INIT_IER  = 3'd5;
  localparam logic [2:0] PASS      = 3'd6;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [15:0]       div_r;
  logic              armed_r;    // low until the first enabled edge after reset
  logic              busy_r;
  logic              done_r;
  logic              rd_pend_r;

  logic              in_pass_s;
  logic              in_init_s;
  logic              init_fire_s;
  logic              restart_s;
  logic              rd_acc_s;
  logic [ADDR_W-1:0] init_addr_s;
  logic [7:0]        init_byte_s;

  // One-hot byte-lane strobe selected by the low address bits
  function automatic logic [STRB_W-1:0] lane_strb(input logic [ADDR_W-1:0] addr);
    logic [STRB_W-1:0] s;
    for (int i = 0; i < STRB_W; i++) begin
      if ((int'(addr) % STRB_W) == i) begin
        s[i] = 1'b1;
      end else begin
        s[i] = 1'b0;
      end
    end
    return s;
  endfunction

  assign in_pass_s   = (state_r == PASS);
  // An unknown encoding is never treated as an init state, so it cannot issue a stray write
  assign in_init_s   = (state_r <= INIT_IER);
  assign init_fire_s = in_init_s & armed_r & u_iob_ready_i;
  assign restart_s   = in_pass_s & start_i & ~h_iob_avalid_i & ~rd_pend_r;
  assign rd_acc_s    = in_pass_s & h_iob_avalid_i & u_iob_ready_i &
                       (h_iob_wstrb_i == {STRB_W{1'b0}});

  // Register address and byte value written in each init state
  always_comb begin
    init_addr_s = ADDR_W'(32'd0);
    init_byte_s = 8'h00;
    case (state_r)
      INIT_DLAB: begin init_addr_s = ADDR_W'(32'd3); init_byte_s = 8'h83;       end
      INIT_DLL:  begin init_addr_s = ADDR_W'(32'd0); init_byte_s = div_r[7:0];  end
      INIT_DLM:  begin init_addr_s = ADDR_W'(32'd1); init_byte_s = div_r[15:8]; end
      INIT_LCR:  begin init_addr_s = ADDR_W'(32'd3); init_byte_s = 8'h03;       end
      INIT_FCR:  begin init_addr_s = ADDR_W'(32'd2); init_byte_s = 8'h07;       end
      INIT_IER:  begin init_addr_s = ADDR_W'(32'd1); init_byte_s = IER_VAL;     end
      default:   begin init_addr_s = ADDR_W'(32'd0); init_byte_s = 8'h00;       end
    endcase
  end

  // Next-state logic: each init write advances on accept, PASS waits for a clean restart
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT_DLAB: if (init_fire_s) state_nxt_s = INIT_DLL; else state_nxt_s = state_r;
      INIT_DLL:  if (init_fire_s) state_nxt_s = INIT_DLM; else state_nxt_s = state_r;
      INIT_DLM:  if (init_fire_s) state_nxt_s = INIT_LCR; else state_nxt_s = state_r;
      INIT_LCR:  if (init_fire_s) state_nxt_s = INIT_FCR; else state_nxt_s = state_r;
      INIT_FCR:  if (init_fire_s) state_nxt_s = INIT_IER; else state_nxt_s = state_r;
      INIT_IER:  if (init_fire_s) state_nxt_s = PASS;     else state_nxt_s = state_r;
      PASS:      if (restart_s)   state_nxt_s = INIT_DLAB; else state_nxt_s = state_r;
      default:   state_nxt_s = INIT_DLAB;
    endcase
  end

  // Sequencer state, divisor latch, status flags and pending-read tracker
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r   <= INIT_DLAB;
      div_r     <= 16'h0000;
      armed_r   <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      rd_pend_r <= 1'b0;
    end else if (cke_i) begin
      state_r <= state_nxt_s;
      if (!armed_r) begin
        armed_r <= 1'b1;
        div_r   <= div_i;
      end else if (restart_s) begin
        div_r   <= div_i;
      end else begin
        div_r   <= div_r;
      end
      if (restart_s) begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end else if ((state_r == INIT_IER) && init_fire_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
        done_r <= done_r;
      end
      if (rd_acc_s) begin
        rd_pend_r <= 1'b1;
      end else if (in_pass_s && u_iob_rvalid_i) begin
        rd_pend_r <= 1'b0;
      end else begin
        rd_pend_r <= rd_pend_r;
      end
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;

  // Bus mux: host passthrough in PASS, sequencer-driven writes otherwise
  always_comb begin
    if (in_pass_s) begin
      u_iob_avalid_o = h_iob_avalid_i;
      u_iob_addr_o   = h_iob_addr_i;
      u_iob_wdata_o  = h_iob_wdata_i;
      u_iob_wstrb_o  = h_iob_wstrb_i;
      h_iob_ready_o  = u_iob_ready_i;
      h_iob_rvalid_o = u_iob_rvalid_i;
      h_iob_rdata_o  = u_iob_rdata_i;
    end else begin
      u_iob_avalid_o = in_init_s & armed_r;
      u_iob_addr_o   = init_addr_s;
      u_iob_wdata_o  = {STRB_W{init_byte_s}};
      u_iob_wstrb_o  = lane_strb(init_addr_s);
      h_iob_ready_o  = 1'b0;
      h_iob_rvalid_o = 1'b0;
      h_iob_rdata_o  = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_iob_uart16550_init_arb.sv
// Testbench for iob_uart16550_init_arb: directed scenarios with a
// scoreboard of expected UART init writes and host read data.
module tb_iob_uart16550_init_arb;

  localparam logic [7:0] IER_VAL = 8'h05;

  logic        clk, arst_n, cke, start;
  logic [15:0] div;
  logic        busy, done;
  logic        h_avalid, h_rvalid, h_ready;
  logic [2:0]  h_addr;
  logic [31:0] h_wdata, h_rdata;
  logic [3:0]  h_wstrb;
  logic        u_avalid, u_rvalid, u_ready;
  logic [2:0]  u_addr;
  logic [31:0] u_wdata, u_rdata;
  logic [3:0]  u_wstrb;

  typedef struct packed {
    logic [2:0]  addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  int          wr_cyc_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          init_wr_cnt = 0;
  int          host_acc = 0;
  int          acc0;
  int          span;

  iob_uart16550_init_arb #(.ADDR_W(3), .DATA_W(32), .IER_VAL(IER_VAL)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .start_i(start), .div_i(div),
    .busy_o(busy), .done_o(done),
    .h_iob_avalid_i(h_avalid), .h_iob_addr_i(h_addr), .h_iob_wdata_i(h_wdata),
    .h_iob_wstrb_i(h_wstrb), .h_iob_rvalid_o(h_rvalid), .h_iob_rdata_o(h_rdata),
    .h_iob_ready_o(h_ready),
    .u_iob_avalid_o(u_avalid), .u_iob_addr_o(u_addr), .u_iob_wdata_o(u_wdata),
    .u_iob_wstrb_o(u_wstrb), .u_iob_rvalid_i(u_rvalid), .u_iob_rdata_i(u_rdata),
    .u_iob_ready_i(u_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check that init writes are back-to-back
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endfunction

  task automatic push_wr(input logic [2:0] a, input logic [3:0] s, input logic [7:0] b);
    wr_t e;
    e.addr = a;
    e.strb = s;
    e.data = {4{b}};
    exp_wr_q.push_back(e);
  endtask

  task automatic push_head(input logic [15:0] d);
    push_wr(3'd3, 4'b1000, 8'h83);
    push_wr(3'd0, 4'b0001, d[7:0]);
    push_wr(3'd1, 4'b0010, d[15:8]);
    push_wr(3'd3, 4'b1000, 8'h03);
  endtask

  task automatic push_init(input logic [15:0] d);
    push_head(d);
    push_wr(3'd2, 4'b0100, 8'h07);
    push_wr(3'd1, 4'b0010, IER_VAL);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!(done === 1'b1 && busy === 1'b0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk1({name, "_done"}, done, 1'b1);
  endtask

  // Monitor: pops the scoreboard on every init write accept and host read return
  initial begin
    wr_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (arst_n === 1'b1 && cke === 1'b1 && u_avalid === 1'b1 && u_ready === 1'b1 && busy === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL init_write_unexpected: got addr %0d data %h expected none", u_addr, u_wdata);
        end else begin
          e = exp_wr_q.pop_front();
          chk32("init_addr", 32'(u_addr), 32'(e.addr));
          chk32("init_wstrb", 32'(u_wstrb), 32'(e.strb));
          chk32("init_wdata", u_wdata, e.data);
          wr_cyc_q.push_back(cyc);
          init_wr_cnt++;
        end
      end
      if (arst_n === 1'b1 && h_rvalid === 1'b1) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL host_rvalid_unexpected: got %h expected none", h_rdata);
        end else begin
          r = exp_rd_q.pop_front();
          chk32("host_rdata", h_rdata, r);
        end
      end
      if (arst_n === 1'b1 && cke === 1'b1 && h_avalid === 1'b1 && h_ready === 1'b1) host_acc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; cke = 1'b1; start = 1'b0; div = 16'h0036;
    h_avalid = 1'b0; h_addr = 3'd0; h_wdata = 32'd0; h_wstrb = 4'd0;
    u_rvalid = 1'b0; u_rdata = 32'd0; u_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_u_avalid", u_avalid, 1'b0);
    chk1("rst_h_ready", h_ready, 1'b0);
    chk32("rst_h_rdata", h_rdata, 32'd0);

    // S1: six back-to-back writes after reset release
    push_init(16'h0036);
    @(posedge clk); #1 arst_n = 1'b1;
    wait_done("s1");
    chk1("s1_busy", busy, 1'b0);
    chk32("s1_wr_count", 32'(init_wr_cnt), 32'd6);
    span = (wr_cyc_q.size() >= 6) ? (wr_cyc_q[5] - wr_cyc_q[0]) : -1;
    chk32("s1_wr_span", 32'(span), 32'd5);
    step();

    // S2: ready low for 3 cycles on the DLL write
    push_init(16'h0036);
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("s2_entry_busy", busy, 1'b1);
    chk1("s2_entry_done", done, 1'b0);
    step();
    u_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) u_ready = 1'b1;
      @(negedge clk);
      chk1("s2_hold_avalid", u_avalid, 1'b1);
      chk32("s2_hold_addr", 32'(u_addr), 32'd0);
      chk32("s2_hold_wdata", u_wdata, 32'h3636_3636);
      step();
    end
    wait_done("s2");
    step();

    // S3: host read of addr 5 passes through
    h_avalid = 1'b1; h_addr = 3'd5; h_wstrb = 4'd0; h_wdata = 32'd0;
    @(negedge clk);
    chk1("s3_u_avalid", u_avalid, 1'b1);
    chk32("s3_u_addr", 32'(u_addr), 32'd5);
    chk32("s3_u_wstrb", 32'(u_wstrb), 32'd0);
    chk1("s3_h_ready", h_ready, 1'b1);
    step();
    h_avalid = 1'b0;
    u_rvalid = 1'b1; u_rdata = 32'h0000_6000;
    exp_rd_q.push_back(32'h0000_6000);
    @(negedge clk);
    chk1("s3_h_rvalid", h_rvalid, 1'b1);
    step();
    u_rvalid = 1'b0; u_rdata = 32'd0;

    // S4: start while a host read is pending
    h_avalid = 1'b1; h_addr = 3'd5; h_wstrb = 4'd0;
    step();
    h_avalid = 1'b0;
    start = 1'b1; div = 16'hA5C3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("s4_pending_busy", busy, 1'b0);
      step();
    end
    u_rvalid = 1'b1; u_rdata = 32'h0000_1100;
    exp_rd_q.push_back(32'h0000_1100);
    push_init(16'hA5C3);
    @(negedge clk);
    chk1("s4_rvalid_cycle_busy", busy, 1'b0);
    step();
    u_rvalid = 1'b0; u_rdata = 32'd0;
    @(negedge clk);
    chk1("s4_after_rvalid_busy", busy, 1'b0);
    step();
    chk1("s4_entry_busy", busy, 1'b1);
    chk1("s4_entry_done", done, 1'b0);
    step();
    step();
    start = 1'b0;
    wait_done("s4");
    step();

    // S5: host request during init is held off until PASS
    div = 16'h0001;
    push_init(16'h0001);
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("s5_entry_busy", busy, 1'b1);
    h_avalid = 1'b1; h_addr = 3'd7; h_wstrb = 4'b1000; h_wdata = 32'h5A00_0000;
    acc0 = host_acc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      chk1("s5_h_ready_init", h_ready, 1'b0);
    end
    chk1("s5_done", done, 1'b1);
    chk1("s5_pass_avalid", u_avalid, 1'b1);
    chk32("s5_pass_addr", 32'(u_addr), 32'd7);
    chk32("s5_pass_wstrb", 32'(u_wstrb), 32'b1000);
    chk32("s5_pass_wdata", u_wdata, 32'h5A00_0000);
    chk1("s5_pass_h_ready", h_ready, 1'b1);
    step();
    h_avalid = 1'b0; h_wstrb = 4'd0;
    chk32("s5_host_accepts", 32'(host_acc - acc0), 32'd1);

    // S6: reset during the FCR write, then a cke stall
    div = 16'h0102;
    push_head(16'h0102);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    u_ready = 1'b0;
    @(negedge clk);
    chk32("s6_fcr_addr", 32'(u_addr), 32'd2);
    chk32("s6_fcr_wstrb", 32'(u_wstrb), 32'b0100);
    #2 arst_n = 1'b0;
    #1;
    chk1("s6_rst_busy", busy, 1'b1);
    chk1("s6_rst_done", done, 1'b0);
    chk1("s6_rst_avalid", u_avalid, 1'b0);
    div = 16'h0050;
    push_init(16'h0050);
    @(posedge clk); #1 arst_n = 1'b1;
    u_ready = 1'b1;
    step();
    div = 16'hFFFF;
    step();
    step();
    cke = 1'b0;
    @(negedge clk);
    chk32("s6_cke_addr0", 32'(u_addr), 32'd1);
    step();
    @(negedge clk);
    chk32("s6_cke_addr1", 32'(u_addr), 32'd1);
    chk1("s6_cke_busy", busy, 1'b1);
    step();
    cke = 1'b1;
    wait_done("s6");
    step();

    chk32("sb_wr_empty", 32'(exp_wr_q.size()), 32'd0);
    chk32("sb_rd_empty", 32'(exp_rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
